// File: rtl/t5_fetch.sv
// t5_fetch: multi-hart instruction fetch unit for the t5 barrel core.
// Round-robin issue over enabled harts onto a Wishbone classic I-port, one
// tagged instruction delivered per ack, per-hart redirects kill stale fetches.
// Optional bus-error support (iwb_err/ferr, hart parking) is built when
// T5_FETCH_BUSERR_EN is defined; the default build has no error path.
module t5_fetch #(
  parameter int              XLEN         = 32,
  parameter int              HLEN         = 2,
  parameter logic [XLEN-1:0] RESET_VEC    = 32'h0000_0000,
  parameter logic [XLEN-1:0] RESET_STRIDE = 32'h0000_0100
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   sys_ena,
  input  logic [(1<<HLEN)-1:0]   hart_ena,
  input  logic                   xbra,
  input  logic [HLEN-1:0]        xhart,
  input  logic [XLEN-1:0]        xbpc,
  output logic [29:0]            iwb_adr,
  output logic                   iwb_stb,
  output logic                   iwb_wre,
  output logic [3:0]             iwb_sel,
  input  logic                   iwb_ack,
  input  logic [31:0]            iwb_dat,
`ifdef T5_FETCH_BUSERR_EN
  input  logic                   iwb_err,
  output logic                   ferr,
`endif
  output logic                   fvld,
  output logic [31:0]            finst,
  output logic [XLEN-1:0]        fpc,
  output logic [HLEN-1:0]        fhart
);

  localparam int HARTS = 1 << HLEN;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc     [HARTS];
  logic [XLEN-1:0] w_pc_nxt [HARTS];
  logic [XLEN-1:2] r_adr;     // word address of the in-flight fetch
  logic [HLEN-1:0] r_cur;     // hart owning the in-flight fetch
  logic [HLEN-1:0] r_ptr;     // last issued hart (round-robin origin)
  logic            r_kill;    // in-flight fetch was redirected, drop it
  logic            r_fvld;
  logic [31:0]     r_finst;
  logic [XLEN-1:0] r_fpc;
  logic [HLEN-1:0] r_fhart;

  logic            w_busy, w_done, w_xcur, w_stale, w_ack_ok, w_any, w_issue;
  logic [HLEN-1:0] w_sel;
  logic [HARTS-1:0] w_park_nxt, w_elig;
  logic [XLEN-1:0] w_tgt;

  assign w_busy   = (r_state == S_BUSY);
  assign w_xcur   = xbra && (xhart == r_cur);
  // A redirect of the current hart in the completing cycle counts as a kill.
  assign w_stale  = r_kill || w_xcur;
  assign w_ack_ok = w_busy && iwb_ack && !w_stale;
  assign w_tgt    = xbpc & ~XLEN'(3);

`ifdef T5_FETCH_BUSERR_EN
  logic [HARTS-1:0] r_park;
  logic             r_ferr;
  logic             w_err_hit;

  assign w_done    = w_busy && (iwb_ack || iwb_err);
  assign w_err_hit = w_busy && iwb_err && !iwb_ack && !w_stale;
  assign ferr      = r_ferr;

  // Park a faulting hart; a redirect to it releases the park (redirect wins).
  always_comb begin
    w_park_nxt = r_park;
    for (int h = 0; h < HARTS; h++) begin
      if (w_err_hit && r_cur == HLEN'(h)) w_park_nxt[h] = 1'b1;
      if (xbra && xhart == HLEN'(h))      w_park_nxt[h] = 1'b0;
    end
  end

  // Park bits and the bus-error pulse.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_park <= '0;
      r_ferr <= 1'b0;
    end else begin
      r_park <= w_park_nxt;
      r_ferr <= w_err_hit;
    end
  end
`else
  assign w_done     = w_busy && iwb_ack;
  assign w_park_nxt = '0;
`endif

  assign w_elig = hart_ena & ~w_park_nxt;

  // Next PC per hart: +4 on a good ack, redirect target overrides.
  always_comb begin
    for (int h = 0; h < HARTS; h++) begin
      w_pc_nxt[h] = r_pc[h];
      if (w_ack_ok && r_cur == HLEN'(h)) w_pc_nxt[h] = r_pc[h] + XLEN'(4);
      if (xbra && xhart == HLEN'(h))     w_pc_nxt[h] = w_tgt;
    end
  end

  // Round-robin pick: nearest eligible hart after r_ptr; r_ptr itself is last.
  always_comb begin
    w_sel = r_ptr;
    w_any = |w_elig;
    for (int i = HARTS; i >= 1; i--) begin
      if (w_elig[r_ptr + HLEN'(i)]) w_sel = r_ptr + HLEN'(i);
    end
  end

  assign w_issue = sys_ena && w_any && (!w_busy || w_done);

  // Per-hart program counters.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      for (int h = 0; h < HARTS; h++) r_pc[h] <= RESET_VEC + XLEN'(h) * RESET_STRIDE;
    end else begin
      for (int h = 0; h < HARTS; h++) r_pc[h] <= w_pc_nxt[h];
    end
  end

  // Issue FSM plus registered delivery of completed fetches.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state <= S_IDLE;
      r_adr   <= '0;
      r_cur   <= '0;
      r_ptr   <= HLEN'(HARTS - 1);
      r_kill  <= 1'b0;
      r_fvld  <= 1'b0;
      r_finst <= '0;
      r_fpc   <= '0;
      r_fhart <= '0;
    end else begin
      r_fvld <= 1'b0;
      if (w_done) begin
        r_fvld  <= w_ack_ok;
        r_finst <= iwb_dat;
        r_fpc   <= {r_adr, 2'b00};
        r_fhart <= r_cur;
        r_kill  <= 1'b0;
      end else if (w_busy && w_xcur) begin
        r_kill  <= 1'b1;
      end
      if (w_issue) begin
        r_state <= S_BUSY;
        r_cur   <= w_sel;
        r_ptr   <= w_sel;
        r_adr   <= w_pc_nxt[w_sel][XLEN-1:2];
        r_kill  <= 1'b0;
      end else if (w_done) begin
        r_state <= S_IDLE;
      end
    end
  end

  assign iwb_stb = w_busy;
  assign iwb_adr = r_adr[31:2];
  assign iwb_wre = 1'b0;
  assign iwb_sel = 4'hF;
  assign fvld    = r_fvld;
  assign finst   = r_finst;
  assign fpc     = r_fpc;
  assign fhart   = r_fhart;

endmodule

// File: tb/tb_t5_fetch.sv
// Bench for t5_fetch (HLEN=2, XLEN=32): directed scenarios plus a random run,
// all checked each cycle against a transaction-level reference model.
module tb_t5_fetch;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        sys_ena = 1'b0;
  logic [3:0]  hart_ena = '0;
  logic        xbra = 1'b0;
  logic [1:0]  xhart = '0;
  logic [31:0] xbpc = '0;
  logic        iwb_ack = 1'b0;
  logic [31:0] iwb_dat = '0;
  logic        tb_err = 1'b0;
  logic [29:0] iwb_adr;
  logic        iwb_stb, iwb_wre, fvld;
  logic [3:0]  iwb_sel;
  logic [31:0] finst, fpc;
  logic [1:0]  fhart;
`ifdef T5_FETCH_BUSERR_EN
  logic        ferr;
`endif

  t5_fetch dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .sys_ena(sys_ena), .hart_ena(hart_ena),
    .xbra(xbra), .xhart(xhart), .xbpc(xbpc),
    .iwb_adr(iwb_adr), .iwb_stb(iwb_stb), .iwb_wre(iwb_wre), .iwb_sel(iwb_sel),
    .iwb_ack(iwb_ack), .iwb_dat(iwb_dat),
`ifdef T5_FETCH_BUSERR_EN
    .iwb_err(tb_err), .ferr(ferr),
`endif
    .fvld(fvld), .finst(finst), .fpc(fpc), .fhart(fhart)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one outstanding fetch, per-hart PCs and park flags.
  logic [31:0] m_pc [4];
  bit          m_park [4];
  bit          m_busy, m_stale;
  int          m_cur, m_last;
  logic [31:0] m_adr;
  bit          m_fvld, m_ferr;
  logic [31:0] m_finst, m_fpc, m_fhart;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int h = 0; h < 4; h++) begin
      m_pc[h] = 32'(h) * 32'h100;
      m_park[h] = 1'b0;
    end
    m_busy = 0; m_stale = 0; m_cur = 0; m_last = 3; m_adr = '0;
    m_fvld = 0; m_ferr = 0; m_finst = '0; m_fpc = '0; m_fhart = '0;
  endtask

  // Predict the state after the coming rising edge from the current inputs.
  task automatic model_update();
    bit done, hit, okack, errhit, found;
    int sel;
    m_fvld = 0; m_ferr = 0;
    done = m_busy && (iwb_ack || tb_err);
    hit  = xbra && (int'(xhart) == m_cur);
    if (done) begin
      okack  = iwb_ack && !m_stale && !hit;
      errhit = !iwb_ack && tb_err && !m_stale && !hit;
      m_fvld = okack; m_ferr = errhit;
      m_finst = iwb_dat; m_fpc = m_adr; m_fhart = 32'(m_cur);
      if (okack) m_pc[m_cur] = m_pc[m_cur] + 32'd4;
      if (errhit) m_park[m_cur] = 1'b1;
    end else if (m_busy && hit) begin
      m_stale = 1;
    end
    if (xbra) begin
      m_pc[xhart] = xbpc & 32'hFFFF_FFFC;
      m_park[xhart] = 1'b0;
    end
    if (!m_busy || done) begin
      found = 0; sel = 0;
      if (sys_ena)
        for (int k = 1; k <= 4 && !found; k++) begin
          sel = (m_last + k) % 4;
          if (hart_ena[sel] && !m_park[sel]) found = 1;
        end
      if (found) begin
        m_busy = 1; m_cur = sel; m_last = sel; m_adr = m_pc[sel]; m_stale = 0;
      end else begin
        m_busy = 0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("stb", 32'(iwb_stb), 32'(m_busy));
    if (m_busy) chk("adr", 32'(iwb_adr), 32'(m_adr[31:2]));
    chk("fvld", 32'(fvld), 32'(m_fvld));
    if (m_fvld) begin
      chk("finst", finst, m_finst);
      chk("fpc", fpc, m_fpc);
      chk("fhart", 32'(fhart), m_fhart);
    end
`ifdef T5_FETCH_BUSERR_EN
    chk("ferr", 32'(ferr), 32'(m_ferr));
    if (m_ferr) begin
      chk("err_fpc", fpc, m_fpc);
      chk("err_fhart", 32'(fhart), m_fhart);
    end
`endif
    chk("wre", 32'(iwb_wre), 32'd0);
    chk("sel", 32'(iwb_sel), 32'hF);
  endtask

  task automatic cyc();
    model_update();
    @(negedge sys_clk);
    check_outputs();
  endtask

  task automatic do_reset();
    sys_rst = 1'b0; sys_ena = 0; hart_ena = '0; xbra = 0; iwb_ack = 0; tb_err = 0;
    #1;
    chk("rst_stb", 32'(iwb_stb), 32'd0);
    chk("rst_fvld", 32'(fvld), 32'd0);
    chk("rst_finst", finst, 32'd0);
    chk("rst_fpc", fpc, 32'd0);
    chk("rst_fhart", 32'(fhart), 32'd0);
    model_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
  endtask

  initial begin
    logic [29:0] adrq[$];
    logic [1:0]  hq[$];
    logic [31:0] pq[$];
    logic [29:0] exp_adr [5];
    logic [1:0]  exp_h   [5];
    int w;
    exp_adr = '{30'h0, 30'h40, 30'h80, 30'hC0, 30'h1};
    exp_h   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // All harts enabled, zero-wait slave.
    do_reset();
    sys_ena = 1; hart_ena = 4'hF;
    for (int i = 0; i < 6; i++) begin
      iwb_ack = m_busy; iwb_dat = $urandom;
      cyc();
      if (iwb_stb) adrq.push_back(iwb_adr);
      if (fvld) hq.push_back(fhart);
    end
    chk("p1_adr_cnt", 32'(adrq.size() >= 5), 32'd1);
    chk("p1_h_cnt", 32'(hq.size() >= 5), 32'd1);
    for (int k = 0; k < 5 && k < adrq.size(); k++) chk("p1_adr_seq", 32'(adrq[k]), 32'(exp_adr[k]));
    for (int k = 0; k < 5 && k < hq.size(); k++) chk("p1_hart_seq", 32'(hq[k]), 32'(exp_h[k]));

    // Harts 0 and 2, two wait states per fetch.
    do_reset();
    sys_ena = 1; hart_ena = 4'b0101; w = 0; hq.delete(); pq.delete();
    for (int i = 0; i < 30; i++) begin
      bit was_busy;
      was_busy = m_busy;
      iwb_ack = m_busy && (w == 2); iwb_dat = $urandom;
      cyc();
      if (iwb_ack) w = 0; else if (was_busy) w++;
      if (fvld) begin
        hq.push_back(fhart);
        if (fhart == 2'd0) pq.push_back(fpc);
      end
    end
    iwb_ack = 0;
    chk("p2_cnt", 32'(pq.size() >= 3), 32'd1);
    for (int k = 0; k < 3 && k < pq.size(); k++) chk("p2_pc0", pq[k], 32'(k) * 32'd4);
    for (int k = 0; k < hq.size(); k++) chk("p2_alt", 32'(hq[k]), 32'((k % 2) * 2));

    // Redirect of the in-flight hart two cycles before the ack.
    do_reset();
    sys_ena = 1; hart_ena = 4'b0010;
    cyc(); chk("p3_adr", 32'(iwb_adr), 32'h40);
    xbra = 1; xhart = 2'd1; xbpc = 32'h2003; cyc(); xbra = 0;
    cyc();
    iwb_ack = 1; iwb_dat = $urandom; cyc();
    chk("p3_killed", 32'(fvld), 32'd0);
    chk("p3_newadr", 32'(iwb_adr), 32'h800);
    iwb_dat = $urandom; cyc(); iwb_ack = 0;
    chk("p3_fvld", 32'(fvld), 32'd1);
    chk("p3_fpc", fpc, 32'h2000);

    // Redirect coinciding with the ack, then redirect of another hart.
    do_reset();
    sys_ena = 1; hart_ena = 4'b0100;
    cyc();
    iwb_ack = 1; xbra = 1; xhart = 2'd2; xbpc = 32'h3000; iwb_dat = $urandom; cyc(); xbra = 0;
    chk("p4_fvld0", 32'(fvld), 32'd0);
    chk("p4_adr", 32'(iwb_adr), 32'hC00);
    hart_ena = 4'b0001; iwb_dat = $urandom; cyc();
    iwb_ack = 0; xbra = 1; xhart = 2'd3; xbpc = 32'h5000; cyc(); xbra = 0;
    iwb_ack = 1; iwb_dat = $urandom; cyc();
    chk("p4_other_fvld", 32'(fvld), 32'd1);
    chk("p4_other_hart", 32'(fhart), 32'd0);

    // sys_ena low while busy, then no enabled harts.
    sys_ena = 0; iwb_dat = $urandom; cyc(); iwb_ack = 0;
    chk("p5_deliver", 32'(fvld), 32'd1);
    chk("p5_stb_fall", 32'(iwb_stb), 32'd0);
    for (int i = 0; i < 3; i++) begin cyc(); chk("p5_stb_low", 32'(iwb_stb), 32'd0); end
    sys_ena = 1; hart_ena = 4'b0000;
    for (int i = 0; i < 3; i++) begin cyc(); chk("p5_noharts", 32'(iwb_stb), 32'd0); end

    // PC wrap at the top of the address space.
    do_reset();
    hart_ena = 4'b0001; xbra = 1; xhart = 2'd0; xbpc = 32'hFFFF_FFFE; cyc(); xbra = 0;
    sys_ena = 1; cyc();
    iwb_ack = 1; iwb_dat = $urandom; cyc();
    chk("p6_top", fpc, 32'hFFFF_FFFC);
    iwb_dat = $urandom; cyc(); iwb_ack = 0;
    chk("p6_wrap", fpc, 32'h0);

    // Random run.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) hart_ena = 4'($urandom_range(0, 15));
      sys_ena = ($urandom_range(0, 99) < 90);
      iwb_ack = m_busy && ($urandom_range(0, 99) < 60);
`ifdef T5_FETCH_BUSERR_EN
      tb_err = m_busy && !iwb_ack && ($urandom_range(0, 99) < 5);
`endif
      iwb_dat = $urandom;
      xbra = ($urandom_range(0, 99) < 15);
      xhart = 2'($urandom_range(0, 3));
      xbpc = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : 32'($urandom_range(0, 32'hFFFF));
      cyc();
    end
    xbra = 0; iwb_ack = 0; tb_err = 0;

    // Reset asserted mid-transaction; a late ack must be ignored.
    sys_ena = 1; hart_ena = 4'hF; cyc();
    chk("p8_busy", 32'(iwb_stb), 32'd1);
    sys_rst = 0; iwb_ack = 1;
    #1;
    chk("p8_stb", 32'(iwb_stb), 32'd0);
    chk("p8_fvld", 32'(fvld), 32'd0);
    chk("p8_finst", finst, 32'd0);
    chk("p8_fpc", fpc, 32'd0);
    chk("p8_fhart", 32'(fhart), 32'd0);
    model_reset();
    @(negedge sys_clk);
    sys_rst = 1; sys_ena = 0; cyc();
    chk("p8_ack_ignored", 32'(fvld), 32'd0);
    iwb_ack = 0;

`ifdef T5_FETCH_BUSERR_EN
    // Bus error parks hart 1 until it is redirected.
    do_reset();
    sys_ena = 1; hart_ena = 4'b0010;
    cyc();
    tb_err = 1; cyc(); tb_err = 0;
    chk("be_ferr", 32'(ferr), 32'd1);
    chk("be_fpc", fpc, 32'h100);
    chk("be_fhart", 32'(fhart), 32'd1);
    chk("be_fvld", 32'(fvld), 32'd0);
    cyc(); chk("be_parked", 32'(iwb_stb), 32'd0);
    xbra = 1; xhart = 2'd1; xbpc = 32'h400; cyc(); xbra = 0;
    chk("be_resume_adr", 32'(iwb_adr), 32'h100);
    iwb_ack = 1; iwb_dat = $urandom; cyc(); iwb_ack = 0;
    chk("be_resume_fpc", fpc, 32'h400);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/t5_fetch.md
Name: t5_fetch

Overview:
- Parametrised multi-hart instruction fetch unit for the t5 barrel core.
- Scales hart count via HLEN; each hart owns a PC.
- Round-robin issue over enabled harts onto a Wishbone classic instruction port; delivers one tagged instruction per ack.
- Per-hart branch redirects from the execute stage; a redirect kills any stale in-flight fetch for that hart.

Parameters:
- XLEN, 32, datapath/PC width.
- HLEN, 2, hart index width; HARTS = 1<<HLEN.
- RESET_VEC, 32'h0000_0000, reset PC of hart 0.
- RESET_STRIDE, 32'h0000_0100, reset PC of hart h = RESET_VEC + h*RESET_STRIDE.

Ports:
- sys_clk  in  1  clock, rising edge.
- sys_rst  in  1  reset, asynchronous, active-low.
- sys_ena  in  1  issue enable; low blocks new fetches only.
- hart_ena  in  HARTS  per-hart run enable.
- xbra  in  1  redirect strobe from execute.
- xhart  in  HLEN  hart being redirected.
- xbpc  in  XLEN  redirect target.
- iwb_adr  out  30  fetch word address [31:2].
- iwb_stb  out  1  Wishbone strobe/cycle.
- iwb_wre  out  1  tied 0.
- iwb_sel  out  4  tied 4'hF.
- iwb_ack  in  1  Wishbone ack.
- iwb_dat  in  32  fetched word.
- fvld  out  1  instruction valid, one-cycle pulse.
- finst  out  32  instruction word.
- fpc  out  XLEN  PC of finst.
- fhart  out  HLEN  hart of finst.

Behaviour:
- Reset values (sys_rst low, async):
  - pc[h] = RESET_VEC + h*RESET_STRIDE.
  - iwb_stb=0, fvld=0, finst=0, fpc=0, fhart=0, kill=0.
  - Round-robin pointer = HARTS-1, so hart 0 is first.
- FSM has two states.
  - IDLE:
    - iwb_stb=0.
    - If sys_ena and any hart_ena bit is set: latch the selected hart into cur, then go to BUSY.
  - BUSY:
    - iwb_stb=1; iwb_adr = pc[cur][31:2], held stable until ack.
    - On iwb_ack:
      - Registered next cycle: fvld=!kill, finst=iwb_dat, fpc=pc[cur], fhart=cur.
      - pc[cur] += 4 unless killed; kill cleared.
      - If sys_ena and an enabled hart exists, select it and stay in BUSY (stb stays high, new address). This gives 1 instr/cycle with a zero-wait slave.
      - Otherwise go to IDLE.
- Selection: first enabled hart after the last issued hart, in ascending index order, wrapping HARTS-1 -> 0. The pointer updates only on issue.
- A single enabled hart is selected every time.
- Redirect (xbra), registered:
  - pc[xhart] = {xbpc[XLEN-1:2], 2'b00}; low bits are ignored.
  - If BUSY and xhart == cur and no ack in the same cycle: set kill. On completion, fvld=0 and the redirected pc is preserved (no +4).
  - xbra and iwb_ack in the same cycle for the same hart: redirect wins. fvld=0; pc[cur] = target.
  - xbra for another hart: that pc updates; the in-flight fetch is unaffected.
- hart_ena dropping mid-transaction: the transaction completes and is delivered normally; the hart is skipped from the next selection on.
- sys_ena low in BUSY: the outstanding fetch completes and is delivered; no new issue, go to IDLE.
- PC arithmetic is modulo 2^XLEN; 32'hFFFF_FFFC + 4 wraps to 0.
- Reset asserted mid-transaction: stb drops immediately; the ack is ignored after release.
- iwb_wre=0 and iwb_sel=4'hF at all times.

Optional Feature:
- Macro: T5_FETCH_BUSERR_EN.
- Defined:
  - Adds input iwb_err (1) and output ferr (1).
  - iwb_err terminates the cycle like ack, but fvld=0 and pc is not incremented.
  - ferr pulses one cycle, with fhart = cur and fpc = the faulting PC.
  - The hart is parked (skipped by selection) until an xbra for that hart clears the park.
  - err and xbra for the same hart in the same cycle: no park, no ferr.
- Undefined: no iwb_err/ferr ports, no park state.

Test Plan:
- Reset, HLEN=2, all hart_ena=4'hF, ack every cycle:
  - iwb_adr sequence (byte) 0x000, 0x100, 0x200, 0x300, 0x004.
  - fvld continuous from cycle 2; fhart 0,1,2,3,0.
- hart_ena=4'b0101, ack with 2 wait states:
  - Alternating harts 0,2; each stb held 3 cycles; pc[0] advances 0x0, 0x4, 0x8.
- Hart 1 in flight at 0x100, xbra xhart=1 xbpc=0x2003 two cycles before ack:
  - Delivery has fvld=0.
  - Next hart-1 fetch at byte address 0x2000.
- xbra xhart=2 in the same cycle as the ack for hart 2:
  - fvld=0; pc[2]=target.
  - Concurrent xbra to hart 3 while hart 0 is busy: hart-0 delivery is valid.
- sys_ena dropped while BUSY:
  - Instruction delivered; stb falls the following cycle and stays 0.
  - hart_ena=0 also keeps stb at 0.
  - sys_rst pulsed mid-cycle: all outputs return to reset values asynchronously.
- With T5_FETCH_BUSERR_EN:
  - iwb_err on hart 1 at 0x100: ferr=1, fpc=0x100, hart 1 skipped.
  - xbra xhart=1 xbpc=0x400: hart 1 resumes at 0x400.
